// File: rtl/instr_buffer_if.sv
// IF1 -> instruction buffer -> decode bundle.
// The master side is IF1 plus decode; the slave side is the buffer.
interface instr_buffer_if #(
  parameter int IB_DATA_BUS_WD = 81,
  parameter int IB_WIDTH_LOG2  = 4
);
  logic                          flush_IB;
  logic [4*IB_DATA_BUS_WD-1:0]   if1_to_ib;
  logic [2:0]                    push_num;
  logic [IB_WIDTH_LOG2:0]        can_push_size;
  logic [2*IB_DATA_BUS_WD-1:0]   ib_to_id;
  logic [1:0]                    ib_valid_num;
  logic [1:0]                    pop_num;

  modport master (
    output flush_IB,
    output if1_to_ib,
    output push_num,
    output pop_num,
    input  can_push_size,
    input  ib_to_id,
    input  ib_valid_num
  );

  modport slave (
    input  flush_IB,
    input  if1_to_ib,
    input  push_num,
    input  pop_num,
    output can_push_size,
    output ib_to_id,
    output ib_valid_num
  );
endinterface

// File: rtl/instr_buffer.sv
// Circular instruction buffer between IF1 and decode.
// Up to 4 pushes and 2 pops per cycle; presents the two oldest entries.
module instr_buffer #(
  parameter int IB_DATA_BUS_WD = 81,
  parameter int IB_WIDTH       = 16,
  parameter int IB_WIDTH_LOG2  = 4
) (
  input logic           clk,
  input logic           rst,
  instr_buffer_if.slave ib
);

  localparam int W  = IB_DATA_BUS_WD;
  localparam int AW = IB_WIDTH_LOG2;

  logic [W-1:0]  mem [IB_WIDTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW-1:0] head_p1;
  logic [AW:0]   count;
  logic [1:0]    valid_num;
  logic [1:0]    eff_pop;
  logic [AW+1:0] next_cnt;

  always_comb begin
    valid_num = (count >= (AW+1)'(2)) ? 2'd2 : count[1:0];
    eff_pop   = (ib.pop_num > valid_num) ? valid_num : ib.pop_num;
    head_p1   = head + AW'(1);
    next_cnt  = (AW+2)'(count)
              + (AW+2)'(ib.push_num)
              - (AW+2)'(eff_pop);
  end

  assign ib.can_push_size = count;
  assign ib.ib_valid_num  = valid_num;
  assign ib.ib_to_id      = {mem[head_p1], mem[head]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < IB_WIDTH; i++)
        mem[i] <= '0;
    end else if (ib.flush_IB) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      for (int k = 0; k < 4; k++)
        if (3'(k) < ib.push_num)
          mem[tail + AW'(k)] <= ib.if1_to_ib[k*W +: W];
      tail  <= tail + AW'(ib.push_num);
      head  <= head + AW'(eff_pop);
      count <= next_cnt[AW:0];
    end
  end

  // IF1 reserves one slot; overflow here means its admission check broke
  always_ff @(posedge clk or negedge rst) begin
    if (rst && !ib.flush_IB) begin
      assert (ib.push_num <= 3'd4);
      assert (next_cnt <= (AW+2)'(IB_WIDTH - 1));
    end
  end

endmodule

// File: tb/tb_instr_buffer.sv
// Directed bench for instr_buffer.
// Vectors carry hand-computed expected occupancy and slot contents.
module tb_instr_buffer;

  localparam int W = 81;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  instr_buffer_if #(.IB_DATA_BUS_WD(W), .IB_WIDTH_LOG2(4)) bus ();

  instr_buffer #(
    .IB_DATA_BUS_WD(W),
    .IB_WIDTH(16),
    .IB_WIDTH_LOG2(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ib(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [31:0] instr);
    mk = {1'b0, 1'b0, 6'd0, 9'd0, instr << 2, instr};
  endfunction

  // one clock: drive, take the edge, sample #1 later, idle inputs
  task automatic cyc(input logic [2:0]  pn,
                     input logic [1:0]  pp,
                     input logic        fl,
                     input logic [31:0] base);
    bus.push_num = pn;
    bus.pop_num  = pp;
    bus.flush_IB = fl;
    for (int k = 0; k < 4; k++)
      bus.if1_to_ib[k*W +: W] = mk(base + 32'(k));
    @(posedge clk);
    #1;
    bus.push_num  = 3'd0;
    bus.pop_num   = 2'd0;
    bus.flush_IB  = 1'b0;
    bus.if1_to_ib = '0;
  endtask

  function automatic logic [31:0] s0();
    s0 = bus.ib_to_id[31:0];
  endfunction

  function automatic logic [31:0] s1();
    s1 = bus.ib_to_id[W+31:W];
  endfunction

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    bus.push_num  = 3'd0;
    bus.pop_num   = 2'd0;
    bus.flush_IB  = 1'b0;
    bus.if1_to_ib = '0;

    #3;
    check("rst_cps", 64'(bus.can_push_size), 64'd0);
    check("rst_vld", 64'(bus.ib_valid_num), 64'd0);
    check("rst_out", 64'(bus.ib_to_id == '0), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // first push of four
    cyc(3'd4, 2'd0, 1'b0, 32'hA);
    check("p4_cps", 64'(bus.can_push_size), 64'd4);
    check("p4_vld", 64'(bus.ib_valid_num), 64'd2);
    check("p4_s0", 64'(s0()), 64'hA);
    check("p4_s1", 64'(s1()), 64'hB);

    // fill to 12, then push 3 with pop 2
    cyc(3'd4, 2'd0, 1'b0, 32'h10);
    cyc(3'd4, 2'd0, 1'b0, 32'h20);
    check("f12_cps", 64'(bus.can_push_size), 64'd12);
    cyc(3'd3, 2'd2, 1'b0, 32'h30);
    check("pp_cps", 64'(bus.can_push_size), 64'd13);
    check("pp_s0", 64'(s0()), 64'hC);
    check("pp_s1", 64'(s1()), 64'hD);

    // walk pointers to 14 from a clean reset
    rst = 1'b0;
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc(3'd2, 2'd0, 1'b0, 32'h50);
    for (int i = 0; i < 6; i++)
      cyc(3'd2, 2'd2, 1'b0, 32'h60 + 32'(i*2));
    cyc(3'd0, 2'd2, 1'b0, 32'h0);
    check("walk_cps", 64'(bus.can_push_size), 64'd0);

    // wrap: indices 14,15,0,1
    cyc(3'd4, 2'd0, 1'b0, 32'h100);
    check("wr_s0", 64'(s0()), 64'h100);
    check("wr_s1", 64'(s1()), 64'h101);
    cyc(3'd0, 2'd1, 1'b0, 32'h0);
    check("h15_s0", 64'(s0()), 64'h101);
    check("h15_s1", 64'(s1()), 64'h102);
    check("h15_cps", 64'(bus.can_push_size), 64'd3);
    cyc(3'd0, 2'd2, 1'b0, 32'h0);
    check("wr2_s0", 64'(s0()), 64'h103);
    check("wr2_vld", 64'(bus.ib_valid_num), 64'd1);

    // single entry, over-pop clamps
    cyc(3'd0, 2'd2, 1'b0, 32'h0);
    check("one_cps", 64'(bus.can_push_size), 64'd0);
    check("one_vld", 64'(bus.ib_valid_num), 64'd0);
    cyc(3'd0, 2'd2, 1'b0, 32'h0);
    check("emp_cps", 64'(bus.can_push_size), 64'd0);
    cyc(3'd1, 2'd0, 1'b0, 32'h200);
    check("t2_s0", 64'(s0()), 64'h200);
    check("t2_cps", 64'(bus.can_push_size), 64'd1);

    // flush wins over same-cycle push and pop
    cyc(3'd4, 2'd2, 1'b1, 32'h300);
    check("fl_cps", 64'(bus.can_push_size), 64'd0);
    check("fl_vld", 64'(bus.ib_valid_num), 64'd0);
    cyc(3'd2, 2'd0, 1'b0, 32'h400);
    check("fl_s0", 64'(s0()), 64'h400);
    check("fl_s1", 64'(s1()), 64'h401);

    // async reset at count 7
    cyc(3'd4, 2'd0, 1'b0, 32'h500);
    cyc(3'd1, 2'd0, 1'b0, 32'h600);
    check("c7_cps", 64'(bus.can_push_size), 64'd7);
    #2;
    rst = 1'b0;
    #1;
    check("ar_cps", 64'(bus.can_push_size), 64'd0);
    check("ar_vld", 64'(bus.ib_valid_num), 64'd0);
    check("ar_out", 64'(bus.ib_to_id == '0), 64'd1);
    bus.push_num = 3'd4;
    bus.if1_to_ib[0 +: W] = mk(32'h77);
    @(posedge clk);
    #1;
    check("arh_cps", 64'(bus.can_push_size), 64'd0);
    check("arh_out", 64'(bus.ib_to_id == '0), 64'd1);
    bus.push_num  = 3'd0;
    bus.if1_to_ib = '0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // no bypass, and first push lands at index 0
    bus.push_num = 3'd1;
    bus.if1_to_ib[0 +: W] = mk(32'h700);
    #1;
    check("nb_vld", 64'(bus.ib_valid_num), 64'd0);
    cyc(3'd1, 2'd0, 1'b0, 32'h700);
    check("ap_s0", 64'(s0()), 64'h700);
    check("ap_cps", 64'(bus.can_push_size), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
